bist_signature_analyzer: RTL and testbench
==========================================

Name: bist_signature_analyzer

Overview:
- Response compactor at the output end of the built-in test path. The LFSR pattern generator drives stimulus into the circuit under test; this block compresses the circuit's responses into a signature.
- It is a Galois multiple-input signature register (MISR) with a control FSM.
- After a fixed number of valid responses it freezes the signature and compares it against a golden value. The result is a single pass/fail flag.

Parameters:
- WIDTH, 5, response and signature width in bits.
- POLY, 5'b00101, feedback mask applied when the MSB shifts out. Default is x^5+x^2+1.
- SEED, 5'b00000, value loaded into the signature register on start.
- NUM_PATTERNS, 31, number of valid responses compacted per run. Must be ≥1.
- GOLDEN, 5'b00000, expected final signature.
- CW, $clog2(NUM_PATTERNS+1), pattern counter width.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a run. Sampled in IDLE or DONE only.
- resp_valid  input  1  resp_in carries a valid response this cycle.
- resp_in  input  WIDTH  circuit-under-test response word.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE. Holds until the next start or rst.
- pass  output  1  compare result. Valid only while done=1, otherwise 0.
- signature  output  WIDTH  current signature register contents.
- pattern_count  output  CW  number of responses compacted in the current or last run.

Behaviour:
- Reset: rst=1 at any time, asynchronously, forces:
  - state=IDLE
  - signature=SEED
  - pattern_count=0
  - busy=0, done=0, pass=0
- States and transitions:
  - IDLE: outputs at reset values. start=1 → RUN. Signature and count are (re)loaded on that edge.
  - RUN: busy=1. On each edge with resp_valid=1, the signature and count update per the rules below.
    - If resp_valid=1 and pattern_count==NUM_PATTERNS-1 → DONE.
    - On that edge signature gets its final value, pattern_count becomes NUM_PATTERNS, done=1, and pass=(final signature==GOLDEN), using the newly computed value, not the old one.
    - resp_valid=0 means no update (a stall). Stalls may last any number of cycles.
    - start during RUN is ignored.
  - DONE: done=1, busy=0. signature, pattern_count and pass are frozen; resp_valid is ignored. start=1 → RUN with a reload, and done and pass clear on the same edge.
- Compaction on a valid response (all arithmetic is bitwise XOR, WIDTH bits, no carry):
  - fb = signature[WIDTH-1]
  - next = {signature[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0) ^ resp_in
- Latency:
  - The signature reflects a response on the edge it is accepted (one cycle).
  - done and pass assert on the edge that accepts response number NUM_PATTERNS. There is no extra compare cycle.
- Start edge: loads signature=SEED and pattern_count=0. resp_valid on the start cycle itself is not compacted.
- Wrap-around: the counter never exceeds NUM_PATTERNS, and there is no compaction beyond NUM_PATTERNS.
- NUM_PATTERNS=1: the first valid response in RUN goes directly to DONE.
- X/Z on resp_in while resp_valid=0 must not affect state.

Test Plan:
- Reset behaviour: assert rst mid-RUN after 3 of 31 responses → immediately (no clock edge) signature=00000, count=0, busy=0, done=0, pass=0. After release, block stays IDLE until start.
- Basic compaction (NUM_PATTERNS=2, SEED=0): start, then resp 00001 followed by 00010 on consecutive cycles.
  - After the first response, signature=00001.
  - After the second, signature=00000 and done=1.
  - With GOLDEN=00000, pass=1.
- Feedback path (NUM_PATTERNS=2): responses 11111 then 00000 → signature 11111 then 11011. With GOLDEN=11011, pass=1; with GOLDEN=00000, pass=0.
- Stalls: same stimulus as the feedback case with resp_valid low for 4 cycles between the two responses. Signature holds 11111 during the stall, the final value is 11011, and pattern_count=2.
- Full default run: feed the 31 states of the 5-bit LFSR pattern generator (seeded non-zero) as responses.
  - done asserts on exactly the 31st valid edge and count=31.
  - Bench computes the expected signature with a reference model, and pass matches the comparison against GOLDEN.
  - A second start from DONE clears done and pass, reloads SEED, and reproduces an identical signature.
- Ignored inputs: start pulsed during RUN leaves the count unchanged. resp_valid pulses in DONE leave signature and pass unchanged.

Source files
------------

// File: rtl/bist_signature_analyzer_if.sv
// Response/control bundle between the BIST sequencer and the signature analyzer.
// The master drives the run request and the response stream. The slave (the analyzer)
// reports its state and the signature it has compacted.
interface bist_signature_analyzer_if #(
    parameter int WIDTH = 5,
    parameter int CW    = 5
);
    logic             start;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CW-1:0]    pattern_count;

    modport master (
        output start, resp_valid, resp_in,
        input  busy, done, pass, signature, pattern_count
    );

    modport slave (
        input  start, resp_valid, resp_in,
        output busy, done, pass, signature, pattern_count
    );
endinterface

// File: rtl/bist_signature_analyzer.sv
// Galois MISR response compactor with a run-control FSM.
// The block compacts exactly NUM_PATTERNS valid responses, then freezes the signature.
// It also freezes a pass flag that says whether the final signature equals GOLDEN.
// Each accepted response folds in on the same edge, so no extra compare cycle is needed.
module bist_signature_analyzer #(
    parameter int               WIDTH        = 5,
    parameter logic [WIDTH-1:0] POLY         = 5'b00101,
    parameter logic [WIDTH-1:0] SEED         = 5'b00000,
    parameter int               NUM_PATTERNS = 31,
    parameter logic [WIDTH-1:0] GOLDEN       = 5'b00000,
    parameter int               CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    bist_signature_analyzer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Count value when the final response of a run is being accepted.
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PATTERNS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q,   sig_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             pass_q,  pass_d;

    // One MISR step: shift left. If the MSB falls out, fold in the feedback taps.
    // Then XOR in the response word.
    logic [WIDTH-1:0] sig_step;
    assign sig_step = {sig_q[WIDTH-2:0], 1'b0}
                    ^ ({WIDTH{sig_q[WIDTH-1]}} & POLY)
                    ^ bus.resp_in;

    // State and datapath registers. Reset returns everything to the idle/seed values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state and datapath selection.
    // sig_step is only selected on a valid response, so garbage on resp_in during a
    // stall never reaches the state.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                // A new run reloads the seed. A response offered on this cycle is not compacted.
                if (bus.start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (bus.resp_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_IDX) begin
                        // Compare the freshly computed signature, not the registered one.
                        state_d = DONE;
                        pass_d  = (sig_step == GOLDEN);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = SEED;
                cnt_d   = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy          = (state_q == RUN);
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = pass_q & (state_q == DONE);
    assign bus.signature     = sig_q;
    assign bus.pattern_count = cnt_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Bench for the signature analyzer. It runs four parameterizations side by side:
// the default 31-pattern run, two 2-pattern runs that differ only in GOLDEN,
// and a 1-pattern run. Expected signatures come from polynomial arithmetic:
// multiply by x modulo the feedback polynomial, then add the response.
module tb_bist_signature_analyzer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    bist_signature_analyzer_if #(.WIDTH(5), .CW(5)) if_full ();
    bist_signature_analyzer_if #(.WIDTH(5), .CW(2)) if_g0 ();
    bist_signature_analyzer_if #(.WIDTH(5), .CW(2)) if_g1 ();
    bist_signature_analyzer_if #(.WIDTH(5), .CW(1)) if_one ();

    bist_signature_analyzer u_full (.clk(clk), .rst(rst), .bus(if_full));

    bist_signature_analyzer #(.NUM_PATTERNS(2), .GOLDEN(5'b00000))
        u_g0 (.clk(clk), .rst(rst), .bus(if_g0));

    bist_signature_analyzer #(.NUM_PATTERNS(2), .GOLDEN(5'b11011))
        u_g1 (.clk(clk), .rst(rst), .bus(if_g1));

    bist_signature_analyzer #(.NUM_PATTERNS(1))
        u_one (.clk(clk), .rst(rst), .bus(if_one));

    // Multiply a 5-bit polynomial by x, then reduce modulo the full 6-bit polynomial pfull.
    function automatic logic [4:0] mul_x(input logic [4:0] s, input int pfull);
        int v;
        v = int'(s) << 1;
        if (v[5]) v = v ^ pfull;
        return v[4:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic drive2(input logic st, input logic v, input logic [4:0] d);
        if_g0.start = st; if_g0.resp_valid = v; if_g0.resp_in = d;
        if_g1.start = st; if_g1.resp_valid = v; if_g1.resp_in = d;
    endtask

    localparam int MISR_P = 32'h25;  // x^5+x^2+1
    localparam int LFSR_P = 32'h29;  // x^5+x^3+1, primitive, 31 non-zero states

    initial begin
        logic [4:0] resp [31];
        logic [4:0] lfsr, acc, exp_sig, r, held_sig;
        logic       held_pass;

        if_full.start = 0; if_full.resp_valid = 0; if_full.resp_in = 0;
        if_one.start  = 0; if_one.resp_valid  = 0; if_one.resp_in  = 0;
        drive2(0, 0, 0);

        // Reset state while rst is held
        #12;
        chk("rst_sig",  32'(if_full.signature), 0);
        chk("rst_cnt",  32'(if_full.pattern_count), 0);
        chk("rst_busy", 32'(if_full.busy), 0);
        chk("rst_done", 32'(if_full.done), 0);
        chk("rst_pass", 32'(if_full.pass), 0);
        rst = 0;
        tick();

        // Asynchronous reset in the middle of a run
        if_full.start = 1; tick(); if_full.start = 0;
        chk("run_busy", 32'(if_full.busy), 1);
        for (int i = 0; i < 3; i++) begin
            if_full.resp_valid = 1; if_full.resp_in = 5'($urandom); tick();
        end
        if_full.resp_valid = 0;
        chk("mid_cnt", 32'(if_full.pattern_count), 3);
        #2 rst = 1;
        #1;
        chk("arst_sig",  32'(if_full.signature), 0);
        chk("arst_cnt",  32'(if_full.pattern_count), 0);
        chk("arst_busy", 32'(if_full.busy), 0);
        chk("arst_done", 32'(if_full.done), 0);
        chk("arst_pass", 32'(if_full.pass), 0);
        #2 rst = 0;
        for (int i = 0; i < 3; i++) begin
            if_full.resp_valid = 1; if_full.resp_in = 5'($urandom_range(1, 31)); tick();
        end
        if_full.resp_valid = 0;
        chk("idle_busy", 32'(if_full.busy), 0);
        chk("idle_cnt",  32'(if_full.pattern_count), 0);
        chk("idle_sig",  32'(if_full.signature), 0);

        // Basic compaction, 2 patterns
        drive2(1, 0, 0); tick();
        drive2(0, 1, 5'b00001); tick();
        chk("basic_sig1",  32'(if_g0.signature), 5'b00001);
        chk("basic_done1", 32'(if_g0.done), 0);
        drive2(0, 1, 5'b00010); tick();
        drive2(0, 0, 0);
        chk("basic_sig2",  32'(if_g0.signature), 5'b00000);
        chk("basic_done2", 32'(if_g0.done), 1);
        chk("basic_pass",  32'(if_g0.pass), 1);
        chk("basic_npass", 32'(if_g1.pass), 0);

        // Feedback path; the restart from DONE clears done and pass
        drive2(1, 0, 0); tick();
        chk("restart_done", 32'(if_g0.done), 0);
        chk("restart_pass", 32'(if_g0.pass), 0);
        chk("restart_sig",  32'(if_g0.signature), 0);
        chk("restart_cnt",  32'(if_g0.pattern_count), 0);
        drive2(0, 1, 5'b11111); tick();
        chk("fb_sig1", 32'(if_g0.signature), 5'b11111);
        drive2(0, 1, 5'b00000); tick();
        drive2(0, 0, 0);
        chk("fb_sig2",   32'(if_g0.signature), 5'b11011);
        chk("fb_pass0",  32'(if_g0.pass), 0);
        chk("fb_pass1",  32'(if_g1.pass), 1);
        chk("fb_done1",  32'(if_g1.done), 1);

        // Stalls with garbage data; a start pulse inside RUN is ignored
        drive2(1, 0, 0); tick();
        drive2(0, 1, 5'b11111); tick();
        for (int i = 0; i < 4; i++) begin
            drive2(i == 1, 0, 5'($urandom)); tick();
            chk("stall_sig", 32'(if_g1.signature), 5'b11111);
            chk("stall_cnt", 32'(if_g1.pattern_count), 1);
        end
        drive2(0, 1, 5'b00000); tick();
        drive2(0, 0, 0);
        chk("stall_final", 32'(if_g1.signature), 5'b11011);
        chk("stall_cnt2",  32'(if_g1.pattern_count), 2);
        chk("stall_pass",  32'(if_g1.pass), 1);

        // DONE ignores resp_valid
        for (int i = 0; i < 3; i++) begin
            drive2(0, 1, 5'($urandom_range(1, 31))); tick();
        end
        drive2(0, 0, 0);
        chk("doneig_sig",  32'(if_g1.signature), 5'b11011);
        chk("doneig_pass", 32'(if_g1.pass), 1);
        chk("doneig_cnt",  32'(if_g1.pattern_count), 2);

        // Single-pattern run; the response on the start cycle is not compacted
        r = 5'($urandom);
        if_one.start = 1; if_one.resp_valid = 1; if_one.resp_in = 5'($urandom); tick();
        if_one.start = 0; if_one.resp_valid = 0; if_one.resp_in = 5'($urandom); tick();
        chk("one_busy", 32'(if_one.busy), 1);
        if_one.resp_valid = 1; if_one.resp_in = r; tick();
        if_one.resp_valid = 0;
        chk("one_done", 32'(if_one.done), 1);
        chk("one_sig",  32'(if_one.signature), r);
        chk("one_cnt",  32'(if_one.pattern_count), 1);
        chk("one_pass", 32'(if_one.pass), r == 5'd0);

        // Full default run fed with the 31 states of a randomly seeded LFSR
        lfsr = 5'($urandom_range(1, 31));
        exp_sig = 5'd0;
        for (int k = 0; k < 31; k++) begin
            resp[k] = lfsr;
            exp_sig = mul_x(exp_sig, MISR_P) ^ lfsr;
            lfsr    = mul_x(lfsr, LFSR_P);
        end

        for (int run = 0; run < 2; run++) begin
            if_full.start = 1; tick(); if_full.start = 0;
            chk("full_start_done", 32'(if_full.done), 0);
            chk("full_start_pass", 32'(if_full.pass), 0);
            chk("full_start_sig",  32'(if_full.signature), 0);
            chk("full_start_cnt",  32'(if_full.pattern_count), 0);
            acc = 5'd0;
            for (int k = 0; k < 31; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    if_full.resp_valid = 0;
                    if_full.resp_in    = 5'($urandom);
                    if_full.start      = 1'($urandom);
                    tick();
                    chk("full_stall_sig", 32'(if_full.signature), acc);
                    chk("full_stall_cnt", 32'(if_full.pattern_count), k);
                end
                if_full.start = 0; if_full.resp_valid = 1; if_full.resp_in = resp[k];
                tick();
                acc = mul_x(acc, MISR_P) ^ resp[k];
                chk("full_step_sig",  32'(if_full.signature), acc);
                chk("full_step_done", 32'(if_full.done), k == 30);
            end
            if_full.resp_valid = 0;
            chk("full_sig",  32'(if_full.signature), exp_sig);
            chk("full_cnt",  32'(if_full.pattern_count), 31);
            chk("full_busy", 32'(if_full.busy), 0);
            chk("full_pass", 32'(if_full.pass), exp_sig == 5'b00000);

            held_sig  = if_full.signature;
            held_pass = if_full.pass;
            for (int i = 0; i < 2; i++) begin
                if_full.resp_valid = 1; if_full.resp_in = 5'($urandom); tick();
            end
            if_full.resp_valid = 0;
            chk("full_hold_sig",  32'(if_full.signature), held_sig);
            chk("full_hold_pass", 32'(if_full.pass), held_pass);
            chk("full_hold_cnt",  32'(if_full.pattern_count), 31);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
